// File: rtl/gcd_requester_if.sv
// Handshake bundle between a gcd_requester and its surroundings: the valid/ready
// operand and result ports plus the four-phase req/ack bus towards gcd_top.
// master: the requester's view. slave: the host/consumer/gcd_top view.
interface gcd_requester_if #(
  parameter int unsigned W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         req;
  logic [W-1:0] AB;
  logic         ack;
  logic [W-1:0] C;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         out_err;

  modport master (
    input  in_valid, a_in, b_in, ack, C, out_ready,
    output in_ready, req, AB, out_valid, result, out_err
  );

  modport slave (
    output in_valid, a_in, b_in, ack, C, out_ready,
    input  in_ready, req, AB, out_valid, result, out_err
  );
endinterface

// File: rtl/gcd_requester.sv
// Initiator for gcd_top: takes one operand pair, sends A then B over the shared
// AB bus as two full four-phase req/ack cycles, captures C on the second ack and
// offers it on a valid/ready result port. Any single ack wait longer than TIMEOUT
// cycles aborts the transaction and reports out_err.
module gcd_requester #(
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic             clk,
  input logic             reset,
  gcd_requester_if.master bus
);

  localparam int unsigned CntW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);
  localparam bit TimeoutEn = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    StIdle,
    StReqA,
    StRelA,
    StReqB,
    StRelB,
    StAbort,
    StOut
  } state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic [W-1:0]    ab_q, ab_d;
  logic [W-1:0]    b_q, b_d;        // A goes straight onto AB; only B needs holding
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    result_q, result_d;
  logic            out_err_q, out_err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_hit;

  assign timeout_hit = TimeoutEn && (cnt_q == CntMax);

  // Next-state and registered-output logic; every register holds by default.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ab_d        = ab_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_err_d   = out_err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          ab_d    = bus.a_in;
          b_d     = bus.b_in;
          req_d   = 1'b1;
          state_d = StReqA;
        end
      end
      StReqA: begin
        if (timeout_hit) begin
          req_d   = 1'b0;
          state_d = StAbort;
        end else if (bus.ack) begin
          req_d   = 1'b0;
          state_d = StRelA;
        end
      end
      StRelA: begin
        if (timeout_hit) begin
          req_d   = 1'b0;
          state_d = StAbort;
        end else if (!bus.ack) begin
          ab_d    = b_q;
          req_d   = 1'b1;
          state_d = StReqB;
        end
      end
      StReqB: begin
        if (timeout_hit) begin
          req_d   = 1'b0;
          state_d = StAbort;
        end else if (bus.ack) begin
          result_d = bus.C;
          req_d    = 1'b0;
          state_d  = StRelB;
        end
      end
      StRelB: begin
        if (timeout_hit) begin
          req_d   = 1'b0;
          state_d = StAbort;
        end else if (!bus.ack) begin
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
          state_d     = StOut;
        end
      end
      StAbort: begin
        // Never re-arm req until the responder has released ack.
        if (!bus.ack) begin
          result_d    = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = StOut;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // Cycle counter restarts on every state change.
  always_comb begin
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CntW'(1);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      ab_q        <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      ab_q        <= ab_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_err_q   <= out_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && reset;
  assign bus.req       = req_q;
  assign bus.AB        = ab_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_err   = out_err_q;

endmodule
